// File: rtl/ctrl_seq_pkg.sv
// ============================================================================
// Module      : ctrl_seq_pkg
// Description : State encoding shared by the control sequencer and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_seq_if.sv
// ============================================================================
// Module      : ctrl_seq_if
// Description : Fetch, decoder-bundle, data-memory and writeback handshake bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctrl_seq_if;

    logic imem_req;
    logic imem_ack;
    logic ir_load;
    logic regwen_d;
    logic memrw_d;
    logic mem_op_d;
    logic dmem_req;
    logic dmem_ack;
    logic dmem_we;
    logic reg_we;
    logic pc_we;
    logic retire;

    // Sequencer side
    modport master (
        output imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_we, retire,
        input  imem_ack, regwen_d, memrw_d, mem_op_d, dmem_ack
    );

    // Memory / decoder / datapath side
    modport slave (
        input  imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_we, retire,
        output imem_ack, regwen_d, memrw_d, mem_op_d, dmem_ack
    );

endinterface

`default_nettype wire

// File: rtl/ctrl_seq_timeout.sv
// ============================================================================
// Module      : ctrl_seq_timeout
// Description : Ack-wait counter; expires when count reaches TIMEOUT-1 (0 = never).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_seq_timeout #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_en,
    output logic      o_expired
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_limit
            assign o_expired = 1'b0;
        end else begin : g_limit
            localparam logic [TO_W-1:0] c_LIMIT = TO_W'(TIMEOUT - 1);
            assign o_expired = (r_cnt == c_LIMIT);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/ctrl_sequencer.sv
// ============================================================================
// Module      : ctrl_sequencer
// Description : Multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb).
//               Optional performance counters enabled by CTRL_SEQ_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16'd255,
    parameter int unsigned TO_W    = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         run,
    ctrl_seq_if.master        bus,
    output logic              busy,
    output logic              fault,
    output logic [STATE_W-1:0] state_o,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_regwen;
    logic   r_memrw;
    logic   r_memop;
    logic   r_fault;
    logic   w_to_halt;
    logic   w_wait;
    logic   w_in_wait_state;
    logic   w_expired;

    assign w_in_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_wait = ((r_state == ST_FETCH) && !bus.imem_ack) ||
                    ((r_state == ST_MEM)   && !bus.dmem_ack);

    // Counter sits at zero outside FETCH/MEM, so each entry starts a fresh wait
    ctrl_seq_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_in_wait_state),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_regwen <= 1'b0;
            r_memrw  <= 1'b0;
            r_memop  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_DECODE) begin
                r_regwen <= bus.regwen_d;
                r_memrw  <= bus.memrw_d;
                r_memop  <= bus.mem_op_d;
            end
            if (w_to_halt) begin
                r_fault <= 1'b1;
            end
        end
    end

    // An ack arriving on the expiry cycle takes priority over the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_to_halt   = 1'b0;
        case (r_state)
            ST_IDLE:   if (run) w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    w_state_nxt = ST_DECODE;
                end else if (w_expired) begin
                    w_state_nxt = ST_HALT;
                    w_to_halt   = 1'b1;
                end
            end
            ST_DECODE: w_state_nxt = ST_EXEC;
            ST_EXEC:   w_state_nxt = r_memop ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    w_state_nxt = ST_WB;
                end else if (w_expired) begin
                    w_state_nxt = ST_HALT;
                    w_to_halt   = 1'b1;
                end
            end
            ST_WB:     w_state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_HALT:   w_state_nxt = ST_HALT;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.imem_req = (r_state == ST_FETCH);
    assign bus.ir_load  = (r_state == ST_FETCH) && bus.imem_ack;
    assign bus.dmem_req = (r_state == ST_MEM);
    assign bus.dmem_we  = (r_state == ST_MEM) && r_memrw;
    assign bus.reg_we   = (r_state == ST_WB) && r_regwen;
    assign bus.pc_we    = (r_state == ST_WB);
    assign bus.retire   = (r_state == ST_WB);
    assign busy         = (r_state != ST_IDLE);
    assign fault        = r_fault;
    assign state_o      = r_state;

`ifdef CTRL_SEQ_PERF_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt <= 32'd0;
            r_stall_cnt   <= 32'd0;
        end else begin
            if (r_state == ST_WB) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (w_wait) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign stall_cnt   = r_stall_cnt;
`else
    assign retired_cnt = 32'd0;
    assign stall_cnt   = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
// ============================================================================
// Module      : tb_ctrl_sequencer
// Description : Scoreboard bench for ctrl_sequencer (TIMEOUT=4 instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_sequencer;
    import ctrl_seq_pkg::*;

    typedef struct {
        string       tag;
        logic [11:0] vec;
        logic [31:0] ret;
        logic [31:0] stall;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic        busy;
    logic        fault;
    logic [2:0]  state_o;
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;

    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    logic d_regwen;
    logic d_memrw;
    logic d_memop;
    logic [31:0] m_ret;
    logic [31:0] m_stall;

    ctrl_seq_if u_if ();

    ctrl_sequencer #(
        .TIMEOUT (4),
        .TO_W    (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .bus         (u_if),
        .busy        (busy),
        .fault       (fault),
        .state_o     (state_o),
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, ".out"}, {20'd0, state_o, u_if.imem_req, u_if.ir_load, u_if.dmem_req,
                   u_if.dmem_we, u_if.reg_we, u_if.pc_we, u_if.retire, busy, fault},
                  {20'd0, e.vec});
            check({e.tag, ".ret"}, retired_cnt, e.ret);
            check({e.tag, ".stall"}, stall_cnt, e.stall);
        end
    end

    // One clock: drive inputs, push the outputs expected in this cycle
    task automatic cyc(input string tag, input logic r, input logic rn,
                       input logic iack, input logic dack, input logic [2:0] s);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        run              = rn;
        u_if.imem_ack    = iack;
        u_if.dmem_ack    = dack;
        u_if.regwen_d    = d_regwen;
        u_if.memrw_d     = d_memrw;
        u_if.mem_op_d    = d_memop;
        e.tag   = tag;
        e.vec   = {s, (s == 3'd1), (s == 3'd1) && iack, (s == 3'd4), (s == 3'd4) && d_memrw,
                   (s == 3'd5) && d_regwen, (s == 3'd5), (s == 3'd5), (s != 3'd0), (s == 3'd6)};
`ifdef CTRL_SEQ_PERF_EN
        e.ret   = m_ret;
        e.stall = m_stall;
`else
        e.ret   = 32'd0;
        e.stall = 32'd0;
`endif
        sb_q.push_back(e);
        if (s == 3'd5) m_ret++;
        if ((s == 3'd1 && !iack) || (s == 3'd4 && !dack)) m_stall++;
        if (r) begin
            m_ret   = 32'd0;
            m_stall = 32'd0;
        end
    endtask

    task automatic set_instr(input logic rw, input logic mrw, input logic mop);
        d_regwen = rw;
        d_memrw  = mrw;
        d_memop  = mop;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_ret   = 32'd0;
        m_stall = 32'd0;
        rst = 1'b1;
        run = 1'b0;
        u_if.imem_ack = 1'b0;
        u_if.dmem_ack = 1'b0;
        set_instr(1'b0, 1'b0, 1'b0);

        // Reset held with run high
        cyc("rst0", 1, 1, 0, 0, 3'd0);
        cyc("rst1", 1, 1, 0, 0, 3'd0);
        cyc("rst2", 0, 1, 0, 0, 3'd0);

        // ALU op, immediate fetch ack
        set_instr(1'b1, 1'b0, 1'b0);
        cyc("alu.f", 0, 1, 1, 0, 3'd1);
        cyc("alu.d", 0, 1, 0, 0, 3'd2);
        cyc("alu.e", 0, 1, 0, 0, 3'd3);
        cyc("alu.w", 0, 1, 0, 0, 3'd5);

        // Store, dmem ack after 3 wait cycles (ack on expiry cycle wins)
        set_instr(1'b0, 1'b1, 1'b1);
        cyc("st.f", 0, 1, 1, 0, 3'd1);
        cyc("st.d", 0, 1, 0, 0, 3'd2);
        cyc("st.e", 0, 1, 0, 0, 3'd3);
        for (int i = 0; i < 3; i++) cyc("st.mw", 0, 1, 0, 0, 3'd4);
        cyc("st.ma", 0, 1, 0, 1, 3'd4);
        cyc("st.w", 0, 0, 0, 0, 3'd5);
        cyc("st.i", 0, 0, 0, 0, 3'd0);

        // Load with two fetch wait cycles, zero-wait dmem
        set_instr(1'b1, 1'b0, 1'b1);
        cyc("ld.i", 0, 1, 0, 0, 3'd0);
        cyc("ld.fw", 0, 1, 0, 0, 3'd1);
        cyc("ld.fw", 0, 1, 0, 0, 3'd1);
        cyc("ld.fa", 0, 1, 1, 0, 3'd1);
        cyc("ld.d", 0, 1, 0, 0, 3'd2);
        cyc("ld.e", 0, 1, 0, 0, 3'd3);
        cyc("ld.m", 0, 1, 0, 1, 3'd4);
        cyc("ld.w", 0, 1, 0, 0, 3'd5);

        // run dropped in EXEC: instruction completes, then IDLE
        set_instr(1'b1, 1'b0, 1'b0);
        cyc("rd.f", 0, 1, 1, 0, 3'd1);
        cyc("rd.d", 0, 1, 0, 0, 3'd2);
        cyc("rd.e", 0, 0, 0, 0, 3'd3);
        cyc("rd.w", 0, 0, 0, 0, 3'd5);
        cyc("rd.i", 0, 0, 0, 0, 3'd0);

        // Reset during MEM
        set_instr(1'b1, 1'b0, 1'b1);
        cyc("rm.i", 0, 1, 0, 0, 3'd0);
        cyc("rm.f", 0, 1, 1, 0, 3'd1);
        cyc("rm.d", 0, 1, 0, 0, 3'd2);
        cyc("rm.e", 0, 1, 0, 0, 3'd3);
        cyc("rm.m", 1, 1, 0, 0, 3'd4);
        cyc("rm.i2", 0, 0, 0, 0, 3'd0);

        // Fetch timeout: 4 FETCH cycles then HALT, sticky until rst
        set_instr(1'b0, 1'b0, 1'b0);
        cyc("tf.i", 0, 1, 0, 0, 3'd0);
        for (int i = 0; i < 4; i++) cyc("tf.f", 0, 1, 0, 0, 3'd1);
        cyc("tf.h", 0, 1, 1, 1, 3'd6);
        cyc("tf.h", 0, 0, 1, 0, 3'd6);
        cyc("tf.h", 1, 1, 0, 0, 3'd6);
        cyc("tf.r", 0, 1, 0, 0, 3'd0);

        // Data-memory timeout
        set_instr(1'b1, 1'b1, 1'b1);
        cyc("tm.f", 0, 1, 1, 0, 3'd1);
        cyc("tm.d", 0, 1, 0, 0, 3'd2);
        cyc("tm.e", 0, 1, 0, 0, 3'd3);
        for (int i = 0; i < 4; i++) cyc("tm.m", 0, 1, 0, 0, 3'd4);
        cyc("tm.h", 0, 1, 0, 1, 3'd6);
        cyc("tm.h", 1, 0, 0, 0, 3'd6);
        cyc("tm.r", 0, 0, 0, 0, 3'd0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
